// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode legality helper for the
// arbitrated execute ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_XOR    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_SLT    = 4'b0101;
    localparam logic [3:0] ALU_SLL    = 4'b0110;
    localparam logic [3:0] ALU_SRL    = 4'b0111;
    localparam logic [3:0] ALU_EQ     = 4'b1000;
    localparam logic [3:0] ALU_SRA    = 4'b1001;
    localparam logic [3:0] ALU_NE     = 4'b1010;
    localparam logic [3:0] ALU_OP_MAX = 4'b1010;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } arb_state_t;

    function automatic logic op_illegal(input logic [3:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle combinational execute ALU; undefined opcodes yield zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic [DATA_WIDTH-1:0]    ALUResult
);

    logic [4:0] shamt;

    // Operation decode; shift amounts come from the low five bits of SrcB only.
    always_comb begin
        shamt     = SrcB[4:0];
        ALUResult = {DATA_WIDTH{1'b0}};
        case (Operation)
            ALU_AND: ALUResult = SrcA & SrcB;
            ALU_OR:  ALUResult = SrcA | SrcB;
            ALU_ADD: ALUResult = SrcA + SrcB;
            ALU_XOR: ALUResult = SrcA ^ SrcB;
            ALU_SUB: ALUResult = SrcA - SrcB;
            ALU_SLT: ALUResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            ALU_SLL: ALUResult = SrcA << shamt;
            ALU_SRL: ALUResult = SrcA >> shamt;
            ALU_EQ:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            ALU_SRA: ALUResult = $unsigned($signed(SrcA) >>> shamt);
            ALU_NE:  ALUResult = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
            default: ALUResult = {DATA_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute ALU among NUM_REQ requesters with a
// single operation in flight and a held valid/ready response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int  DATA_WIDTH    = 32,
    parameter int  OPCODE_LENGTH = 4,
    parameter int  NUM_REQ       = 2,
    localparam int ID_W          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_src_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_src_b,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0]   req_op,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_result,
    output logic [ID_W-1:0]                    rsp_id,
    output logic                               rsp_err
);

    arb_state_t                 state_r;
    arb_state_t                 state_next;
    logic [ID_W-1:0]            rr_ptr_r;
    logic [ID_W-1:0]            ptr_next;
    logic [ID_W-1:0]            cand_id;
    logic [ID_W-1:0]            grant_id;
    logic                       grant_found;
    logic                       transfer;
    logic [DATA_WIDTH-1:0]      op_a_r;
    logic [DATA_WIDTH-1:0]      op_b_r;
    logic [OPCODE_LENGTH-1:0]   op_r;
    logic [ID_W-1:0]            id_r;
    logic [DATA_WIDTH-1:0]      alu_result;

    // Round-robin search from rr_ptr; re-evaluated every cycle, never locked.
    always_comb begin
        cand_id     = {ID_W{1'b0}};
        grant_id    = {ID_W{1'b0}};
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_id = ID_W'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_id    = cand_id;
            end else begin
                grant_found = grant_found;
            end
        end
        ptr_next  = ID_W'((int'(grant_id) + 1) % NUM_REQ);
        req_ready = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state_r == ARB_IDLE) && !reset && grant_found && (grant_id == ID_W'(i));
        end
        transfer = |(req_valid & req_ready);
    end

    // Next-state logic for the IDLE -> EXEC -> RESP -> IDLE sequence.
    always_comb begin
        state_next = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (transfer) state_next = ARB_EXEC;
                else          state_next = ARB_IDLE;
            end
            ARB_EXEC: state_next = ARB_RESP;
            ARB_RESP: begin
                if (rsp_ready) state_next = ARB_IDLE;
                else           state_next = ARB_RESP;
            end
            default:  state_next = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= ARB_IDLE;
        else       state_r <= state_next;
    end

    // Operand capture, pointer advance and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r   <= {ID_W{1'b0}};
            op_a_r     <= {DATA_WIDTH{1'b0}};
            op_b_r     <= {DATA_WIDTH{1'b0}};
            op_r       <= {OPCODE_LENGTH{1'b0}};
            id_r       <= {ID_W{1'b0}};
            rsp_valid  <= 1'b0;
            rsp_result <= {DATA_WIDTH{1'b0}};
            rsp_id     <= {ID_W{1'b0}};
            rsp_err    <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (transfer) begin
                        op_a_r   <= req_src_a[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                        op_b_r   <= req_src_b[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                        op_r     <= req_op[int'(grant_id)*OPCODE_LENGTH +: OPCODE_LENGTH];
                        id_r     <= grant_id;
                        rr_ptr_r <= ptr_next;
                    end
                end
                ARB_EXEC: begin
                    rsp_result <= op_illegal(4'(op_r)) ? {DATA_WIDTH{1'b0}} : alu_result;
                    rsp_id     <= id_r;
                    rsp_err    <= op_illegal(4'(op_r));
                    rsp_valid  <= 1'b1;
                end
                ARB_RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: rsp_valid <= 1'b0;
            endcase
        end
    end

    alu #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPCODE_LENGTH (OPCODE_LENGTH)
    ) u_alu (
        .SrcA      (op_a_r),
        .SrcB      (op_b_r),
        .Operation (op_r),
        .ALUResult (alu_result)
    );

endmodule
